txpybuf_rd: RTL and testbench

- Transmit-side payload buffer reader: the read counterpart of the RX payload word writer that packs decoded bits into 32-bit SRAM words.
- Fetches 32-bit words from the TX payload SRAM, prefetching one word ahead.
- Serializes the words LSB-first onto bufpacketin for the payload bit processor, which advances it with a one-clock bit-advance strobe.
- Sits between the TX payload SRAM and the payload encode path (whitening/FEC/CRC).

---
 rtl/txpybuf_rd_if.sv | 33 +++
 rtl/txpybuf_rd.sv | 154 +++++++++++++++
 tb/tb_txpybuf_rd.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/txpybuf_rd_if.sv
// rtl/txpybuf_rd_if.sv - TX payload buffer reader bus bundle
// Purpose: groups the payload-control, SRAM read and serial-bit signals of txpybuf_rd.
// Ports (master = reader side):
//   py_st_p, pylenbit, pybit_adv_p : payload start / length / bit-advance strobe (in)
//   txpydout                       : SRAM read data, valid the cycle after txpyrd (in)
//   txpyrd, txpyadr                : SRAM read enable / word address (out)
//   bufpacketin                    : current payload bit (out)
//   txpybuf_busy, txpybuf_done_p, txpybuf_urun : status (out)
interface txpybuf_rd_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              py_st_p;
    logic [12:0]       pylenbit;
    logic              pybit_adv_p;
    logic [DATA_W-1:0] txpydout;
    logic              txpyrd;
    logic [ADDR_W-1:0] txpyadr;
    logic              bufpacketin;
    logic              txpybuf_busy;
    logic              txpybuf_done_p;
    logic              txpybuf_urun;

    modport master (
        input  py_st_p, pylenbit, pybit_adv_p, txpydout,
        output txpyrd, txpyadr, bufpacketin, txpybuf_busy, txpybuf_done_p, txpybuf_urun
    );

    modport slave (
        output py_st_p, pylenbit, pybit_adv_p, txpydout,
        input  txpyrd, txpyadr, bufpacketin, txpybuf_busy, txpybuf_done_p, txpybuf_urun
    );
endinterface

// File: rtl/txpybuf_rd.sv
// rtl/txpybuf_rd.sv - TX payload buffer reader, 32-bit SRAM words serialized LSB-first
// Purpose: fetches payload words from the TX payload SRAM (one word prefetched ahead)
//          and presents them bit by bit to the payload bit processor.
// Ports:
//   clk_6M : system clock
//   rst    : synchronous active-high reset
//   bus    : txpybuf_rd_if.master (start/length/advance in, SRAM read, bit and status out)
module txpybuf_rd #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic          clk_6M,
    input  logic          rst,
    txpybuf_rd_if.master  bus
);

    typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, RUN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] nxt_word;
    logic              nxt_vld;
    logic              cap_nxt;
    logic [4:0]        bitidx;
    logic [12:0]       bitcnt;
    logic [12:0]       pylen_q;
    logic [ADDR_W:0]   nwords;
    logic [ADDR_W:0]   words_fetched;
    logic [ADDR_W-1:0] rd_adr;
    logic              rd_en;
    logic              busy;
    logic              done_p;
    logic              urun;

    logic [13:0]       len_rnd;
    logic [ADDR_W:0]   nwords_in;

    // Word count rounded up; 8191 bits -> 256 words needs the extra bit.
    assign len_rnd   = {1'b0, bus.pylenbit} + 14'd31;
    assign nwords_in = (ADDR_W+1)'(len_rnd >> 5);

    assign bus.txpyrd         = rd_en;
    assign bus.txpyadr        = rd_adr;
    assign bus.txpybuf_busy   = busy;
    assign bus.txpybuf_done_p = done_p;
    assign bus.txpybuf_urun   = urun;

    always_comb begin
        bus.bufpacketin = 1'b0;
        if (state == RUN) begin
            bus.bufpacketin = cur_word[bitidx];
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state         <= IDLE;
            cur_word      <= '0;
            nxt_word      <= '0;
            nxt_vld       <= 1'b0;
            cap_nxt       <= 1'b0;
            bitidx        <= '0;
            bitcnt        <= '0;
            pylen_q       <= '0;
            nwords        <= '0;
            words_fetched <= '0;
            rd_adr        <= '0;
            rd_en         <= 1'b0;
            busy          <= 1'b0;
            done_p        <= 1'b0;
            urun          <= 1'b0;
        end else begin
            rd_en  <= 1'b0;
            done_p <= 1'b0;
            // Every read except the first one of a transfer lands in nxt_word.
            // A start pulse discards whatever read is still in flight.
            cap_nxt <= rd_en && (state != LOAD0) && !bus.py_st_p;

            if (bus.py_st_p) begin
                urun          <= 1'b0;
                bitidx        <= '0;
                bitcnt        <= '0;
                nxt_vld       <= 1'b0;
                pylen_q       <= bus.pylenbit;
                nwords        <= nwords_in;
                rd_adr        <= '0;
                if (bus.pylenbit != 13'd0) begin
                    state         <= LOAD0;
                    rd_en         <= 1'b1;
                    words_fetched <= (ADDR_W+1)'(1);
                    busy          <= 1'b1;
                end else begin
                    state         <= DONE;
                    words_fetched <= '0;
                    busy          <= 1'b0;
                end
            end else begin
                case (state)
                    LOAD0: begin
                        state <= LOAD1;
                        if (nwords > (ADDR_W+1)'(1)) begin
                            rd_en         <= 1'b1;
                            rd_adr        <= (ADDR_W)'(1);
                            words_fetched <= (ADDR_W+1)'(2);
                        end
                    end
                    LOAD1: begin
                        cur_word <= bus.txpydout;
                        state    <= RUN;
                        // The first word is not yet on bufpacketin, so a strobe here is lost.
                        if (bus.pybit_adv_p) begin
                            urun <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.pybit_adv_p) begin
                            bitidx <= bitidx + 5'd1;
                            bitcnt <= bitcnt + 13'd1;
                            if (bitcnt == pylen_q - 13'd1) begin
                                state  <= DONE;
                                done_p <= 1'b1;
                                busy   <= 1'b0;
                            end else if (bitidx == 5'd31) begin
                                nxt_vld <= 1'b0;
                                if (nxt_vld) begin
                                    cur_word <= nxt_word;
                                end else begin
                                    // No fresh word: keep the old one and replay it from bit 0.
                                    urun <= 1'b1;
                                end
                                if (words_fetched < nwords) begin
                                    rd_en         <= 1'b1;
                                    rd_adr        <= rd_adr + (ADDR_W)'(1);
                                    words_fetched <= words_fetched + (ADDR_W+1)'(1);
                                end
                            end
                        end
                    end
                    IDLE, DONE: begin
                    end
                    default: state <= IDLE;
                endcase

                // Placed after the word-boundary logic so a word arriving on the
                // boundary edge stays valid rather than being cleared.
                if (cap_nxt) begin
                    nxt_word <= bus.txpydout;
                    nxt_vld  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_txpybuf_rd.sv
// tb/tb_txpybuf_rd.sv - directed self-checking bench for txpybuf_rd
module tb_txpybuf_rd;

    logic        clk_6M = 1'b0;
    logic        rst;
    logic [31:0] mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_cnt = 0;
    int          last_adr = -1;
    int          base;

    txpybuf_rd_if bus_if ();

    txpybuf_rd dut (
        .clk_6M (clk_6M),
        .rst    (rst),
        .bus    (bus_if)
    );

    always #5 clk_6M = ~clk_6M;

    // SRAM model: one-cycle read latency, garbage when not read.
    always @(posedge clk_6M) begin
        if (bus_if.txpyrd) bus_if.txpydout <= mem[bus_if.txpyadr];
        else               bus_if.txpydout <= 32'hDEAD_BEEF;
    end

    // Read monitor: sees the value held during the cycle just ended.
    always @(posedge clk_6M) begin
        if (bus_if.txpyrd === 1'b1) begin
            rd_cnt   = rd_cnt + 1;
            last_adr = int'(bus_if.txpyadr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_6M);
    endtask

    task automatic start(input int len);
        bus_if.py_st_p  = 1'b1;
        bus_if.pylenbit = 13'(len);
        step();
        bus_if.py_st_p  = 1'b0;
    endtask

    task automatic strobe_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) step();
            bus_if.pybit_adv_p = 1'b1;
            step();
            bus_if.pybit_adv_p = 1'b0;
        end
    endtask

    // Called at the first RUN cycle: collects len bits and compares them word by word.
    task automatic run_bits(input string tag, input int len, input int gap);
        logic [31:0] obs;
        logic [31:0] mask;
        int          n;
        obs = '0;
        for (int k = 0; k < len; k++) begin
            obs[k % 32] = bus_if.bufpacketin;
            if ((k % 32) == 31 || k == len - 1) begin
                n    = (k % 32) + 1;
                mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
                check($sformatf("%s word%0d", tag, k / 32), obs & mask, mem[k / 32] & mask);
                obs = '0;
            end
            repeat (gap - 1) step();
            bus_if.pybit_adv_p = 1'b1;
            step();
            bus_if.pybit_adv_p = 1'b0;
        end
        check({tag, " done_p"}, 32'(bus_if.txpybuf_done_p), 32'd1);
        check({tag, " busy_end"}, 32'(bus_if.txpybuf_busy), 32'd0);
        check({tag, " bit_end"}, 32'(bus_if.bufpacketin), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h3C5A_96E1;
        mem[0] = 32'hA5A5_0F0F;
        mem[1] = 32'h0000_00C3;

        rst                = 1'b1;
        bus_if.py_st_p     = 1'b0;
        bus_if.pylenbit    = '0;
        bus_if.pybit_adv_p = 1'b0;
        repeat (3) step();
        check("rst txpyrd", 32'(bus_if.txpyrd), 32'd0);
        check("rst txpyadr", 32'(bus_if.txpyadr), 32'd0);
        check("rst bit", 32'(bus_if.bufpacketin), 32'd0);
        check("rst busy", 32'(bus_if.txpybuf_busy), 32'd0);
        check("rst done", 32'(bus_if.txpybuf_done_p), 32'd0);
        check("rst urun", 32'(bus_if.txpybuf_urun), 32'd0);
        rst = 1'b0;
        step();

        // 40-bit payload, strobe every 6 clocks
        base = rd_cnt;
        start(40);
        check("p40 rd0", 32'(bus_if.txpyrd), 32'd1);
        check("p40 adr0", 32'(bus_if.txpyadr), 32'd0);
        check("p40 busy", 32'(bus_if.txpybuf_busy), 32'd1);
        step();
        check("p40 rd1", 32'(bus_if.txpyrd), 32'd1);
        check("p40 adr1", 32'(bus_if.txpyadr), 32'd1);
        step();
        run_bits("p40", 40, 6);
        check("p40 reads", 32'(rd_cnt - base), 32'd2);
        check("p40 urun", 32'(bus_if.txpybuf_urun), 32'd0);
        step();
        check("p40 done_clr", 32'(bus_if.txpybuf_done_p), 32'd0);

        // Zero-length payload
        base = rd_cnt;
        start(0);
        check("p0 txpyrd", 32'(bus_if.txpyrd), 32'd0);
        check("p0 busy", 32'(bus_if.txpybuf_busy), 32'd0);
        check("p0 done", 32'(bus_if.txpybuf_done_p), 32'd0);
        step();
        check("p0 done2", 32'(bus_if.txpybuf_done_p), 32'd0);
        check("p0 reads", 32'(rd_cnt - base), 32'd0);

        // Maximum payload at the fastest legal rate
        base = rd_cnt;
        start(8191);
        step();
        step();
        run_bits("pmax", 8191, 2);
        check("pmax reads", 32'(rd_cnt - base), 32'd256);
        check("pmax last_adr", 32'(last_adr), 32'd255);
        check("pmax urun", 32'(bus_if.txpybuf_urun), 32'd0);

        // Strobe during LOAD1: underrun, strobe lost, urun sticky until restart
        start(40);
        step();
        bus_if.pybit_adv_p = 1'b1;
        step();
        bus_if.pybit_adv_p = 1'b0;
        check("ur set", 32'(bus_if.txpybuf_urun), 32'd1);
        run_bits("ur", 40, 2);
        check("ur sticky", 32'(bus_if.txpybuf_urun), 32'd1);
        step();
        start(40);
        check("ur clear", 32'(bus_if.txpybuf_urun), 32'd0);
        step();
        step();
        run_bits("ur2", 40, 2);

        // Restart mid-RUN at word 3, bit 10
        base = rd_cnt;
        start(200);
        step();
        step();
        strobe_n(106, 2);
        check("rs bit", 32'(bus_if.bufpacketin), 32'(mem[3][10]));
        check("rs reads", 32'(rd_cnt - base), 32'd5);
        check("rs last_adr", 32'(last_adr), 32'd4);
        base = rd_cnt;
        start(40);
        check("rs rd0", 32'(bus_if.txpyrd), 32'd1);
        check("rs adr0", 32'(bus_if.txpyadr), 32'd0);
        check("rs busy", 32'(bus_if.txpybuf_busy), 32'd1);
        step();
        step();
        check("rs first", 32'(bus_if.bufpacketin), 32'(mem[0][0]));
        run_bits("rs", 40, 2);
        check("rs reads2", 32'(rd_cnt - base), 32'd2);

        // Reset mid-RUN at bit 17
        start(200);
        step();
        step();
        strobe_n(17, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr txpyrd", 32'(bus_if.txpyrd), 32'd0);
        check("mr txpyadr", 32'(bus_if.txpyadr), 32'd0);
        check("mr bit", 32'(bus_if.bufpacketin), 32'd0);
        check("mr busy", 32'(bus_if.txpybuf_busy), 32'd0);
        check("mr done", 32'(bus_if.txpybuf_done_p), 32'd0);
        check("mr urun", 32'(bus_if.txpybuf_urun), 32'd0);
        start(40);
        check("mr rd0", 32'(bus_if.txpyrd), 32'd1);
        step();
        step();
        run_bits("mr", 40, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
